// File: rtl/freq_measure_ctrl_if.sv
// Bundle of the frequency-measurement signals shared by the sequencer and its user.
//   signal      : asynchronous measured input
//   period      : new gate window length, sampled on period_load
//   period_load : one-cycle strobe that samples period
//   ten_count   : BCD tens digit
//   unit_count  : BCD units digit
//   load        : one-cycle strobe, digits valid for the display driver
//   overflow    : last result exceeded 99
// The master modport drives the stimulus side. The slave modport is the sequencer.
interface freq_measure_ctrl_if #(
  parameter int unsigned BITS = 12
);
  logic            signal;
  logic [BITS-1:0] period;
  logic            period_load;
  logic [3:0]      ten_count;
  logic [3:0]      unit_count;
  logic            load;
  logic            overflow;

  modport master (
    output signal, period, period_load,
    input  ten_count, unit_count, load, overflow
  );

  modport slave (
    input  signal, period, period_load,
    output ten_count, unit_count, load, overflow
  );
endinterface

// File: rtl/freq_measure_ctrl.sv
// Measurement sequencer for the two-digit frequency display.
// The sequencer counts rising edges of an asynchronous input over a gate window of clk cycles.
// It converts the count to two BCD digits by repeated subtraction of 10. It then pulses load
// for one cycle so the display driver can capture the digits.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : freq_measure_ctrl_if slave (signal/period/period_load in, digits/load/overflow out)
module freq_measure_ctrl #(
  parameter int unsigned UPDATE_PERIOD = 1200,
  parameter int unsigned BITS          = 12
) (
  input logic                clk,
  input logic                reset,
  freq_measure_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StCount, StTens, StUnits} state_e;

  localparam logic [BITS-1:0] MaxCnt      = '1;
  localparam logic [BITS-1:0] ResetPeriod = BITS'(UPDATE_PERIOD);

  state_e          r_state, w_state_next;
  logic            r_sync1, r_sync2, r_sync3;
  logic            w_edge;
  logic [BITS-1:0] r_win_cnt, r_edge_cnt, w_edge_final;
  logic [BITS-1:0] r_period_act, r_period_pend;
  logic [BITS-1:0] r_work;
  logic [3:0]      r_tens_acc;
  logic [3:0]      r_ten, r_unit;
  logic            r_ovf;
  logic            w_load;
  logic            w_win_last, w_tens_step, w_tens_ovf;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= bus.signal;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge       = r_sync2 & ~r_sync3;
  // The edge seen on the final window cycle still counts. The count saturates at all-ones.
  assign w_edge_final = (w_edge && (r_edge_cnt != MaxCnt)) ? r_edge_cnt + BITS'(1) : r_edge_cnt;
  assign w_win_last   = (r_state == StCount) && (r_win_cnt == r_period_act - BITS'(1));
  assign w_tens_step  = (r_work >= BITS'(10)) && (r_tens_acc < 4'd9);
  assign w_tens_ovf   = (r_work >= BITS'(10)) && (r_tens_acc == 4'd9);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StCount;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StCount: if (w_win_last) w_state_next = StTens;
      StTens:  if (!w_tens_step) w_state_next = StUnits;
      StUnits: w_state_next = StCount;
      default: w_state_next = StCount;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_load = 1'b0;
    if (r_state == StUnits) w_load = 1'b1;
  end

  // Datapath: window/edge counting, period registers, BCD conversion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_cnt     <= '0;
      r_edge_cnt    <= '0;
      r_period_act  <= ResetPeriod;
      r_period_pend <= ResetPeriod;
      r_work        <= '0;
      r_tens_acc    <= '0;
      r_ten         <= '0;
      r_unit        <= '0;
      r_ovf         <= 1'b0;
    end else begin
      // Periods shorter than 2 cycles cannot form a window, so they are dropped.
      if (bus.period_load && (bus.period >= BITS'(2))) begin
        r_period_pend <= bus.period;
      end
      unique case (r_state)
        StCount: begin
          // A window counter of 0 marks the first window cycle. The active period is updated
          // here, never mid-window. Because the active period is at least 2, the
          // last-cycle compare cannot fire on this cycle.
          if (r_win_cnt == '0) r_period_act <= r_period_pend;
          if (w_win_last) begin
            r_work     <= w_edge_final;
            r_tens_acc <= '0;
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
          end else begin
            r_win_cnt  <= r_win_cnt + BITS'(1);
            r_edge_cnt <= w_edge_final;
          end
        end
        StTens: begin
          if (w_tens_step) begin
            r_work     <= r_work - BITS'(10);
            r_tens_acc <= r_tens_acc + 4'd1;
          end else if (w_tens_ovf) begin
            r_ten  <= 4'd9;
            r_unit <= 4'd9;
            r_ovf  <= 1'b1;
          end else begin
            r_ten  <= r_tens_acc;
            r_unit <= r_work[3:0];
            r_ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ten_count  = r_ten;
  assign bus.unit_count = r_unit;
  assign bus.overflow   = r_ovf;
  assign bus.load       = w_load;

endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Self-checking bench for freq_measure_ctrl.
// Each gate window receives a burst of a known number of rising edges. When the window
// starts, the expected digits and the expected load cycle go into a scoreboard queue. A
// monitor pops the queue on every load pulse and compares.
module tb_freq_measure_ctrl;

  localparam int unsigned UpdatePeriod = 1200;
  localparam int unsigned Bits         = 12;

  typedef struct {
    int ten;
    int unit;
    int ovf;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   prev_load = 1'b0;
  exp_t sb[$];

  freq_measure_ctrl_if #(.BITS(Bits)) bus ();

  freq_measure_ctrl #(
    .UPDATE_PERIOD(UpdatePeriod),
    .BITS         (Bits)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Monitor: every load pulse must match the oldest expected result, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.load) begin
      chk("load_width", int'(prev_load), 0);
      chk("load_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ten_count", int'(bus.ten_count), e.ten);
        chk("unit_count", int'(bus.unit_count), e.unit);
        chk("overflow", int'(bus.overflow), e.ovf);
        chk("load_cycle", cyc, e.cyc);
      end
    end
    prev_load = bus.load;
  end

  // Call this task at the negedge of a window's first cycle. It returns at the negedge of
  // the window's last cycle. It sends k rising edges. It can pulse period_load at offset
  // pl_off (0 = none). It leaves signal at end_lvl on the last window cycle, where any edge
  // lands during conversion and is discarded.
  task automatic run_window(input int k, input int plen, input bit end_lvl, input int pl_off,
                            input int pl_val, input bit push);
    int   s;
    exp_t e;
    s = cyc;
    if (push) begin
      if (k >= 100) begin
        e.ten = 9; e.unit = 9; e.ovf = 1;
        e.cyc = s + plen - 1 + 11;
      end else begin
        e.ten = k / 10; e.unit = k % 10; e.ovf = 0;
        e.cyc = s + plen - 1 + k / 10 + 2;
      end
      sb.push_back(e);
    end
    for (int t = 1; t < plen; t++) begin
      @(negedge clk);
      if (k > 0 && t <= 2 * k + 1) bus.signal = (t >= 2 && (t % 2) == 0);
      if (t == pl_off) begin
        bus.period      = Bits'(pl_val);
        bus.period_load = 1'b1;
      end else begin
        bus.period_load = 1'b0;
      end
      if (t == plen - 1) bus.signal = end_lvl;
    end
  endtask

  // Wait for the conversion's load pulse, then step to the next window's first cycle.
  task automatic wait_next();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (bus.load) seen = 1'b1;
    end
    chk("load_seen", int'(seen), 1);
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    bus.signal      = 1'b0;
    bus.period      = '0;
    bus.period_load = 1'b0;

    // Hold reset while signal toggles. All outputs must stay quiet.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_outputs",
          int'({bus.ten_count, bus.unit_count, bus.load, bus.overflow}), 0);
      bus.signal = ~bus.signal;
    end
    @(negedge clk);
    reset      = 1'b0;
    bus.signal = 1'b0;

    // W0: reset period of 1200 cycles. Program 100 for the next window.
    run_window(3, 1200, 1'b0, 10, 100, 1'b1);   wait_next();
    // W1: nominal 25 edges gives 2,5 with load 4 cycles after the window end.
    run_window(25, 100, 1'b0, 0, 0, 1'b1);      wait_next();
    // W2: single digit. Leave signal high for the next window.
    run_window(7, 100, 1'b1, 0, 0, 1'b1);       wait_next();
    // W3: signal held high, so zero edges. Program 400.
    run_window(0, 100, 1'b0, 20, 400, 1'b1);    wait_next();
    // W4: 150 edges overflows to 9,9.
    run_window(150, 400, 1'b0, 0, 0, 1'b1);     wait_next();
    // W5: back to 4,2 with overflow cleared. Program 100.
    run_window(42, 400, 1'b0, 30, 100, 1'b1);   wait_next();
    // W6: 45 edges over 90 cycles. A mid-window change to 50 must not shorten this window.
    run_window(45, 100, 1'b0, 50, 50, 1'b1);    wait_next();
    // W7: 50-cycle window. A period of 1 must be ignored.
    run_window(20, 50, 1'b0, 10, 1, 1'b1);      wait_next();
    // W8: still 50 cycles. Program 200 for the reset test.
    run_window(3, 50, 1'b0, 10, 200, 1'b1);     wait_next();
    // W9: 85 edges. Reset lands in the middle of the tens loop.
    run_window(85, 200, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_load", int'(bus.load), 0);
      chk("rst_mid_out", int'({bus.ten_count, bus.unit_count, bus.overflow}), 0);
    end
    reset = 1'b0;
    // W10: after reset, the reset period of 1200 is back in force.
    run_window(61, 1200, 1'b0, 0, 0, 1'b1);     wait_next();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass,
             n_checks);
    $fatal(1, "watchdog");
  end

endmodule
